// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter feeding one four-phase req/ack crossing; holds the winner's payload and ID on the bus.
// Latency: accept in cycle t, xreq/xdata/xid valid from edge t+1; ack seen SYNC_STAGES edges after it is sampled.
// Backpressure: in_ready pulses only in IDLE with ack_s low; a requester holds in_valid until it gets that pulse.
module cdc_req_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0,
  parameter int IDW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_a,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             xreq,
  output logic [W-1:0]     xdata,
  output logic [IDW-1:0]   xid,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ_HI = 2'd1;
  localparam logic [1:0] REQ_LO = 2'd2;

  localparam int TMRW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [IDW-1:0]         ptr;
  logic [TMRW-1:0]        tmr;
  logic                   grant_vld;
  logic [IDW-1:0]         grant_id;
  logic [IDW:0]           cand;
  logic                   accept;

  always_ff @(posedge clk_a) begin
    if (reset) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // First valid requester at or after ptr, wrapping; cand carries one extra bit so the wrap compare is exact.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDW + 1)'(i);
      if (cand >= (IDW + 1)'(N)) begin
        cand = cand - (IDW + 1)'(N);
      end
      if (!grant_vld && in_valid[cand[IDW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[IDW-1:0];
      end
    end
  end

  // Gated by reset so no accept is ever reported while the block is being cleared.
  assign accept = (state == IDLE) && !ack_s && grant_vld && !reset;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = accept && (grant_id == IDW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ_HI;
      REQ_HI:  if (ack_s)  state_nxt = REQ_LO;
      REQ_LO:  if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      state       <= IDLE;
      xreq        <= 1'b0;
      xdata       <= '0;
      xid         <= '0;
      ptr         <= '0;
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      xreq  <= (state_nxt == REQ_HI);
      if (accept) begin
        xdata <= in_data[grant_id*W +: W];
        xid   <= grant_id;
        ptr   <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
      end
      // Counter saturates at TIMEOUT; the flag is set on the edge the count reaches it.
      if (state_nxt != state) begin
        tmr <= '0;
      end else if (state != IDLE && tmr != TMRW'(TIMEOUT)) begin
        tmr <= tmr + 1'b1;
      end
      if (TIMEOUT != 0 && state != IDLE && state_nxt == state && tmr == TMRW'(TLIM)) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Directed bench for cdc_req_arbiter: stimulus pushes expected grants into a queue,
// a monitor pops one on every in_ready pulse and checks the latched crossing bus.
module tb_cdc_req_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [3:0] rdy;
    logic [7:0] dat;
    logic [1:0] id;
  } exp_t;

  logic        clk_a    = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  in_valid = 4'h0;
  logic [31:0] in_data  = 32'hD3C2_B1A0;
  logic [3:0]  in_ready;
  logic        xreq;
  logic [7:0]  xdata;
  logic [1:0]  xid;
  logic        ack_in   = 1'b0;
  logic        busy;
  logic        timeout_err;
  logic        auto_ack = 1'b0;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   n_acc   = 0;

  cdc_req_arbiter #(.N(N), .W(W), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk_a(clk_a), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .xreq(xreq), .xdata(xdata), .xid(xid),
    .ack_in(ack_in), .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 clk_a = ~clk_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_a);
    #1;
  endtask

  task automatic push_exp(input int idx, input logic [7:0] d);
    exp_t e;
    e.rdy = 4'b0001 << idx;
    e.dat = d;
    e.id  = 2'(idx);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    int c = 0;
    while (n_acc < target && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, n_acc, target);
  endtask

  // Four-phase far side answering one cycle after the request changes.
  initial forever begin
    @(posedge clk_a);
    #2;
    if (auto_ack) ack_in = xreq;
  end

  initial forever begin
    exp_t e;
    @(negedge clk_a);
    if (in_ready != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", in_ready, 0);
      end else begin
        e = sb.pop_front();
        chk("grant_onehot", in_ready, e.rdy);
        n_acc++;
        @(posedge clk_a);
        #1;
        chk("xreq_after_accept", xreq, 1);
        chk("xdata_after_accept", xdata, e.dat);
        chk("xid_after_accept", xid, e.id);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    // Reset held three cycles with every requester asking.
    in_valid = 4'hF;
    repeat (3) begin
      @(negedge clk_a);
      chk("rst_in_ready", in_ready, 0);
    end
    @(posedge clk_a);
    #1;
    chk("rst_xreq", xreq, 0);
    chk("rst_xdata", xdata, 0);
    chk("rst_xid", xid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    in_valid = 4'h0;
    reset    = 1'b0;
    tick(1);

    // Single transfer from requester 2, ack sampled high at edge 5, low at edge 10.
    in_data[23:16] = 8'hA5;
    push_exp(2, 8'hA5);
    in_valid = 4'b0100;
    tick(1);
    in_valid = 4'b0000;
    tick(3);
    ack_in = 1'b1;
    tick(2);
    chk("single_xreq_edge6", xreq, 1);
    tick(1);
    chk("single_xreq_edge7", xreq, 0);
    chk("single_busy_edge7", busy, 1);
    tick(2);
    ack_in = 1'b0;
    tick(2);
    chk("single_busy_edge11", busy, 1);
    chk("single_xdata_hold", xdata, 8'hA5);
    tick(1);
    chk("single_busy_edge12", busy, 0);
    in_data[23:16] = 8'hC2;

    // Fairness with all four asking, then with 1010.
    do_reset();
    push_exp(0, 8'hA0); push_exp(1, 8'hB1); push_exp(2, 8'hC2);
    push_exp(3, 8'hD3); push_exp(0, 8'hA0); push_exp(1, 8'hB1);
    auto_ack = 1'b1;
    in_valid = 4'hF;
    wait_acc(n_acc + 6, 400, "fair_all_count");
    in_valid = 4'h0;
    wait_idle(40, "fair_all_idle");
    do_reset();
    push_exp(1, 8'hB1); push_exp(3, 8'hD3); push_exp(1, 8'hB1); push_exp(3, 8'hD3);
    in_valid = 4'b1010;
    wait_acc(n_acc + 4, 300, "fair_1010_count");
    in_valid = 4'h0;
    wait_idle(40, "fair_1010_idle");
    chk("fair_no_timeout_err", timeout_err, 0);

    // Back-to-back from requester 0; its new data must not disturb the held payload.
    do_reset();
    push_exp(0, 8'hA0);
    push_exp(0, 8'h5A);
    in_valid = 4'b0001;
    tick(1);
    in_data[7:0] = 8'h5A;
    c = 0;
    while (c < 60) begin
      @(negedge clk_a);
      if (!busy) break;
      if (!xreq) chk("b2b_xdata_hold_req_lo", xdata, 8'hA0);
      c++;
    end
    chk("b2b_regrant_first_idle", in_ready, 4'b0001);
    @(posedge clk_a);
    #1;
    in_valid = 4'h0;
    wait_idle(40, "b2b_idle");
    auto_ack = 1'b0;
    in_data[7:0] = 8'hA0;

    // Reset during REQ_HI clears the pointer: next grant goes to 0.
    do_reset();
    push_exp(2, 8'hC2);
    in_valid = 4'b0100;
    tick(1);
    reset    = 1'b1;
    in_valid = 4'hF;
    tick(1);
    chk("midrst_xreq", xreq, 0);
    chk("midrst_busy", busy, 0);
    push_exp(0, 8'hA0);
    reset = 1'b0;
    tick(1);
    in_valid = 4'h0;
    chk("midrst_regrant_count", sb.size(), 0);

    // Timeout: ack withheld, flag rises after 16 cycles in REQ_HI and stays.
    do_reset();
    push_exp(1, 8'hB1);
    in_valid = 4'b0010;
    tick(1);
    in_valid = 4'h0;
    tick(15);
    chk("tmo_err_edge16", timeout_err, 0);
    tick(1);
    chk("tmo_err_edge17", timeout_err, 1);
    chk("tmo_xreq_still_high", xreq, 1);
    ack_in = 1'b1;
    c = 0;
    while (xreq && c < 20) begin
      tick(1);
      c++;
    end
    chk("tmo_xreq_falls", xreq, 0);
    ack_in = 1'b0;
    wait_idle(20, "tmo_idle");
    chk("tmo_err_sticky", timeout_err, 1);

    tick(2);
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
